fifo_write_arbiter: RTL

Round-robin, burst-locking arbiter that shares the single write port of a `cdc_fifo` among `NumRequesters` producers in the write clock domain. Each requester presents valid/last/data. The arbiter grants one requester at a time, holds the grant until that requester's `last` beat (or a burst-length limit), then rotates priority. It sits directly in front of the FIFO's `write_req_i`/`data_i`/`write_valid_o` port.

---
 rtl/fifo_write_arbiter_pkg.sv | 13 +
 rtl/fifo_write_arbiter_if.sv | 26 ++
 rtl/fifo_write_arbiter_rr_pick.sv | 26 ++
 rtl/fifo_write_arbiter.sv | 96 +++++++++
 4 files changed

// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ArbIdle   = 1'b0,
    ArbLocked = 1'b1
  } arb_state_e;

  function automatic int wrap_add(int base, int offset, int modulus);
    return (base + offset) % modulus;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Requester and FIFO-side signals of the write arbiter; slave is the arbiter view.
interface fifo_write_arbiter_if #(
  parameter int NumRequesters = 4,
  parameter int Width         = 8
);
  logic [NumRequesters-1:0]       req_valid_i;
  logic [NumRequesters-1:0]       req_last_i;
  logic [NumRequesters*Width-1:0] req_data_i;
  logic [NumRequesters-1:0]       req_ready_o;
  logic                           fifo_write_req_o;
  logic [Width-1:0]               fifo_data_o;
  logic                           fifo_write_valid_i;
  logic [NumRequesters-1:0]       grant_o;
  logic                           busy_o;
  logic                           burst_trunc_o;

  modport slave (
    input  req_valid_i, req_last_i, req_data_i, fifo_write_valid_i,
    output req_ready_o, fifo_write_req_o, fifo_data_o, grant_o, busy_o, burst_trunc_o
  );

  modport master (
    output req_valid_i, req_last_i, req_data_i, fifo_write_valid_i,
    input  req_ready_o, fifo_write_req_o, fifo_data_o, grant_o, busy_o, burst_trunc_o
  );
endinterface

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after ptr_i, wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int NumRequesters = 4,
  localparam int IdxW          = $clog2(NumRequesters)
) (
  input  logic [NumRequesters-1:0] req_i,
  input  logic [IdxW-1:0]          ptr_i,
  output logic                     valid_o,
  output logic [IdxW-1:0]          idx_o
);

  // Walk from farthest to nearest so the nearest candidate after ptr_i wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = NumRequesters; i >= 1; i--) begin
      if (req_i[wrap_add(int'(ptr_i), i, NumRequesters)]) begin
        valid_o = 1'b1;
        idx_o   = IdxW'(wrap_add(int'(ptr_i), i, NumRequesters));
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-locking arbiter sharing one FIFO write port among requesters.
//   state     | meaning
//   ArbIdle   | no owner; pick next requester after last_idx
//   ArbLocked | owner streams beats until last or MaxBurst
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NumRequesters = 4,
  parameter int Width         = 8,
  parameter int MaxBurst      = 16
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  fifo_write_arbiter_if.slave  bus
);

  localparam int IdxW = $clog2(NumRequesters);
  localparam int CntW = $clog2(MaxBurst + 1);

  arb_state_e      state_q, state_d;
  logic [IdxW-1:0] grant_idx_q, grant_idx_d;
  logic [IdxW-1:0] last_idx_q, last_idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            trunc_q, trunc_d;

  logic            pick_valid;
  logic [IdxW-1:0] pick_idx;
  logic            beat;
  logic            owner_last;
  logic            at_limit;

  rr_pick #(.NumRequesters(NumRequesters)) u_rr_pick (
    .req_i   (bus.req_valid_i),
    .ptr_i   (last_idx_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  assign beat       = (state_q == ArbLocked) & bus.req_valid_i[grant_idx_q] & bus.fifo_write_valid_i;
  assign owner_last = bus.req_last_i[grant_idx_q];
  assign at_limit   = (cnt_q == CntW'(MaxBurst - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ArbIdle;
      grant_idx_q <= '0;
      last_idx_q  <= IdxW'(NumRequesters - 1);
      cnt_q       <= '0;
      trunc_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      last_idx_q  <= last_idx_d;
      cnt_q       <= cnt_d;
      trunc_q     <= trunc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    last_idx_d  = last_idx_q;
    cnt_d       = cnt_q;
    trunc_d     = 1'b0;
    if (state_q == ArbIdle) begin
      if (pick_valid) begin
        state_d     = ArbLocked;
        grant_idx_d = pick_idx;
        cnt_d       = '0;
      end
    end else if (beat) begin
      cnt_d = cnt_q + CntW'(1);
      if (owner_last || at_limit) begin
        state_d    = ArbIdle;
        last_idx_d = grant_idx_q;
        trunc_d    = at_limit & ~owner_last;
      end
    end
  end

  // Owner data only reaches the FIFO while locked; otherwise the bus is zero.
  always_comb begin
    bus.grant_o          = '0;
    bus.req_ready_o      = '0;
    bus.fifo_data_o      = '0;
    bus.fifo_write_req_o = beat;
    bus.busy_o           = (state_q == ArbLocked);
    bus.burst_trunc_o    = trunc_q;
    if (state_q == ArbLocked) begin
      bus.grant_o[grant_idx_q]     = 1'b1;
      bus.req_ready_o[grant_idx_q] = beat;
      bus.fifo_data_o              = bus.req_data_i[int'(grant_idx_q)*Width +: Width];
    end
  end

endmodule
